// File: rtl/score_calc.sv
// Reaction-game scoring: synchronizes buttons/start, times the response window per lit LED,
// and keeps score and round count. Define SCORE_CALC_PENALTY_EN to make a miss cost one point.
module score_calc #(
    parameter int WINDOW_CYCLES = 50000000,
    parameter int ROUNDS        = 10
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic [7:0] led_in,
    input  logic [7:0] btn_in,
    input  logic       start_in,
    output logic       clear_out,
    output logic [7:0] score,
    output logic [3:0] rounds,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LED,
        ARMED,
        RESOLVE,
        WAIT_OFF,
        DONE
    } state_t;

    localparam logic [25:0] WIN_LAST = 26'(WINDOW_CYCLES - 1);
    localparam logic [3:0]  ROUNDS_W = 4'(ROUNDS);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'h00) ? v : v - 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic [25:0] cnt_q, cnt_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  rounds_q, rounds_d;
    logic        clear_q, clear_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        over_q, over_d;

    logic [7:0]  btn_s1_q, btn_s2_q, btn_prev_q;
    logic        st_s1_q, st_s2_q, st_prev_q;

    logic [7:0]  btn_edge;
    logic        start_edge;
    logic        edge_is_hit;
    logic        resolve_en;
    logic        resolve_hit;

    assign btn_edge    = btn_s2_q & ~btn_prev_q;
    assign start_edge  = st_s2_q & ~st_prev_q;
    // Hit needs at least one correct button and no wrong one pressed in the same cycle.
    assign edge_is_hit = (|(btn_edge & led_in)) && !(|(btn_edge & ~led_in));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_d     = score_q;
        rounds_d    = rounds_q;
        clear_d     = 1'b0;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        over_d      = over_q;
        resolve_en  = 1'b0;
        resolve_hit = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    score_d  = 8'd0;
                    rounds_d = 4'd0;
                    over_d   = 1'b0;
                    clear_d  = 1'b1;
                    state_d  = WAIT_LED;
                end
            end
            WAIT_LED: begin
                if (led_in != 8'd0) begin
                    cnt_d   = 26'd0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // A button edge beats both the timeout and an LED dropping in the same cycle.
                if (btn_edge != 8'd0) begin
                    resolve_en  = 1'b1;
                    resolve_hit = edge_is_hit;
                end else if (led_in == 8'd0 || cnt_q == WIN_LAST) begin
                    resolve_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            RESOLVE: begin
                state_d = WAIT_OFF;
            end
            WAIT_OFF: begin
                if (led_in == 8'd0) begin
                    if (rounds_q == ROUNDS_W) begin
                        over_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_LED;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered on entry so they are visible during the RESOLVE cycle.
        if (resolve_en) begin
            state_d  = RESOLVE;
            clear_d  = 1'b1;
            hit_d    = resolve_hit;
            miss_d   = !resolve_hit;
            rounds_d = rounds_q + 4'd1;
            if (resolve_hit) begin
                score_d = sat_inc(score_q);
            end else begin
`ifdef SCORE_CALC_PENALTY_EN
                score_d = sat_dec(score_q);
`else
                score_d = score_q;
`endif
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 26'd0;
            score_q    <= 8'd0;
            rounds_q   <= 4'd0;
            clear_q    <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            over_q     <= 1'b0;
            btn_s1_q   <= 8'd0;
            btn_s2_q   <= 8'd0;
            btn_prev_q <= 8'd0;
            st_s1_q    <= 1'b0;
            st_s2_q    <= 1'b0;
            st_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            score_q    <= score_d;
            rounds_q   <= rounds_d;
            clear_q    <= clear_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            over_q     <= over_d;
            btn_s1_q   <= btn_in;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            st_s1_q    <= start_in;
            st_s2_q    <= st_s1_q;
            st_prev_q  <= st_s2_q;
        end
    end

    assign clear_out  = clear_q;
    assign score      = score_q;
    assign rounds     = rounds_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_score_calc.sv
// Scoreboard bench for score_calc: each round pushes its expected result, and a monitor
// pops and compares whenever a hit/miss strobe appears.
module tb_score_calc;

    localparam int WIN = 8;
    localparam int RND = 3;
`ifdef SCORE_CALC_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led_in = 8'd0;
    logic [7:0] btn_in = 8'd0;
    logic       start_in = 1'b0;
    logic       clear_out;
    logic [7:0] score;
    logic [3:0] rounds;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       game_over;

    always #5 clk = ~clk;

    score_calc #(.WINDOW_CYCLES(WIN), .ROUNDS(RND)) dut (
        .clk_100mhz(clk),
        .rst_n     (rst_n),
        .led_in    (led_in),
        .btn_in    (btn_in),
        .start_in  (start_in),
        .clear_out (clear_out),
        .score     (score),
        .rounds    (rounds),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .game_over (game_over)
    );

    typedef struct packed {
        logic       hit;
        logic [7:0] sc;
        logic [3:0] rd;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] m_score = 8'd0;
    logic [3:0] m_rounds = 4'd0;

    // Monitor: every strobe must match the oldest expected round result.
    always @(negedge clk) begin
        if (rst_n && (hit_pulse || miss_pulse)) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_strobe: hit=%0b miss=%0b, required none", hit_pulse, miss_pulse);
            end else begin
                mon_e = sb.pop_front();
                total_cnt += 5;
                if (hit_pulse !== mon_e.hit) $display("FAIL strobe_hit: got %0b required %0b", hit_pulse, mon_e.hit);
                else pass_cnt++;
                if (miss_pulse !== !mon_e.hit) $display("FAIL strobe_miss: got %0b required %0b", miss_pulse, !mon_e.hit);
                else pass_cnt++;
                if (clear_out !== 1'b1) $display("FAIL resolve_clear: got %0b required 1", clear_out);
                else pass_cnt++;
                if (score !== mon_e.sc) $display("FAIL resolve_score: got %0d required %0d", score, mon_e.sc);
                else pass_cnt++;
                if (rounds !== mon_e.rd) $display("FAIL resolve_rounds: got %0d required %0d", rounds, mon_e.rd);
                else pass_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_round(input bit hit);
        exp_t e;
        if (hit) m_score = (m_score == 8'hFF) ? m_score : m_score + 8'd1;
        else if (PEN && m_score != 8'd0) m_score = m_score - 8'd1;
        m_rounds = m_rounds + 4'd1;
        e.hit = hit;
        e.sc  = m_score;
        e.rd  = m_rounds;
        sb.push_back(e);
    endtask

    // Lights led, then after pre cycles presses btn (or drops the LED when drop is set).
    task automatic play_round(input logic [7:0] led, input logic [7:0] btn, input int pre,
                              input bit drop, input bit hit, input string name);
        int waited;
        led_in = led;
        expect_round(hit);
        tick(pre);
        if (drop) led_in = 8'd0;
        else btn_in = btn;
        waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        total_cnt++;
        if (sb.size() != 0) begin
            $display("FAIL %s_no_strobe: pending %0d results after %0d cycles, required 0", name, sb.size(), waited);
            sb.delete();
        end else pass_cnt++;
        tick(1);
        btn_in = 8'd0;
        led_in = 8'd0;
        tick(4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total_cnt += 6;
        if (clear_out !== 1'b0) $display("FAIL reset_clear: got %0b required 0", clear_out); else pass_cnt++;
        if (score !== 8'd0) $display("FAIL reset_score: got %0d required 0", score); else pass_cnt++;
        if (rounds !== 4'd0) $display("FAIL reset_rounds: got %0d required 0", rounds); else pass_cnt++;
        if (hit_pulse !== 1'b0) $display("FAIL reset_hit: got %0b required 0", hit_pulse); else pass_cnt++;
        if (miss_pulse !== 1'b0) $display("FAIL reset_miss: got %0b required 0", miss_pulse); else pass_cnt++;
        if (game_over !== 1'b0) $display("FAIL reset_over: got %0b required 0", game_over); else pass_cnt++;
        tick(3);
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_start(input string name);
        int seen;
        start_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (clear_out === 1'b1) seen = 1;
        end
        total_cnt += 5;
        if (seen != 1) $display("FAIL %s_clear: got no pulse required clear_out=1", name); else pass_cnt++;
        if (score !== 8'd0) $display("FAIL %s_score: got %0d required 0", name, score); else pass_cnt++;
        if (rounds !== 4'd0) $display("FAIL %s_rounds: got %0d required 0", name, rounds); else pass_cnt++;
        if (game_over !== 1'b0) $display("FAIL %s_over: got %0b required 0", name, game_over); else pass_cnt++;
        @(negedge clk);
        if (clear_out !== 1'b0) $display("FAIL %s_clear_width: got %0b required 0", name, clear_out); else pass_cnt++;
        start_in = 1'b0;
        tick(4);
        m_score  = 8'd0;
        m_rounds = 4'd0;
    endtask

    task automatic test_wait_led_ignore();
        btn_in = 8'h10;
        tick(6);
        btn_in = 8'h00;
        tick(5);
        total_cnt += 2;
        if (rounds !== 4'd0) $display("FAIL waitled_rounds: got %0d required 0", rounds); else pass_cnt++;
        if (score !== 8'd0) $display("FAIL waitled_score: got %0d required 0", score); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int first;
        led_in = 8'h01;
        expect_round(1'b0);
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            @(negedge clk);
            if (hit_pulse || miss_pulse) first = i;
        end
        total_cnt++;
        if (first != 10) $display("FAIL timeout_latency: strobe at cycle %0d required 10", first); else pass_cnt++;
        tick(1);
        led_in = 8'd0;
        tick(4);
    endtask

    task automatic test_last_cycle_hit();
        int first;
        led_in = 8'h01;
        expect_round(1'b1);
        tick(6);
        btn_in = 8'h01;
        first = 0;
        for (int i = 1; i <= 20 && first == 0; i++) begin
            @(negedge clk);
            if (hit_pulse || miss_pulse) first = i;
        end
        total_cnt++;
        if (first != 4) $display("FAIL lastcycle_latency: strobe at cycle %0d required 4", first); else pass_cnt++;
        tick(1);
        btn_in = 8'd0;
        led_in = 8'd0;
        tick(4);
    endtask

    task automatic test_game_over(input logic [7:0] want_score);
        total_cnt += 3;
        if (game_over !== 1'b1) $display("FAIL over_flag: got %0b required 1", game_over); else pass_cnt++;
        if (rounds !== 4'(RND)) $display("FAIL over_rounds: got %0d required %0d", rounds, RND); else pass_cnt++;
        if (score !== want_score) $display("FAIL over_score: got %0d required %0d", score, want_score); else pass_cnt++;
        led_in = 8'h10;
        tick(2);
        btn_in = 8'h10;
        tick(6);
        btn_in = 8'h00;
        led_in = 8'h20;
        tick(6);
        led_in = 8'h00;
        tick(4);
        total_cnt += 3;
        if (game_over !== 1'b1) $display("FAIL over_hold_flag: got %0b required 1", game_over); else pass_cnt++;
        if (rounds !== 4'(RND)) $display("FAIL over_hold_rounds: got %0d required %0d", rounds, RND); else pass_cnt++;
        if (score !== want_score) $display("FAIL over_hold_score: got %0d required %0d", score, want_score); else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int seen;
        logic [3:0] r0;
        r0 = rounds;
        start_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (clear_out === 1'b1) seen = 1;
        end
        start_in = 1'b0;
        tick(4);
        total_cnt += 2;
        if (seen != 0) $display("FAIL midgame_start_clear: got pulse required none"); else pass_cnt++;
        if (rounds !== r0) $display("FAIL midgame_start_rounds: got %0d required %0d", rounds, r0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_round();
        led_in = 8'h10;
        tick(4);
        btn_in = 8'h10;
        rst_n = 1'b0;
        #1;
        total_cnt += 5;
        if (clear_out !== 1'b0) $display("FAIL midreset_clear: got %0b required 0", clear_out); else pass_cnt++;
        if (score !== 8'd0) $display("FAIL midreset_score: got %0d required 0", score); else pass_cnt++;
        if (rounds !== 4'd0) $display("FAIL midreset_rounds: got %0d required 0", rounds); else pass_cnt++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0)
            $display("FAIL midreset_strobes: got %0b%0b required 00", hit_pulse, miss_pulse);
        else pass_cnt++;
        if (game_over !== 1'b0) $display("FAIL midreset_over: got %0b required 0", game_over); else pass_cnt++;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        btn_in = 8'h00;
        led_in = 8'h00;
        tick(6);
        total_cnt += 3;
        if (score !== 8'd0) $display("FAIL postreset_score: got %0d required 0", score); else pass_cnt++;
        if (rounds !== 4'd0) $display("FAIL postreset_rounds: got %0d required 0", rounds); else pass_cnt++;
        if (sb.size() != 0) $display("FAIL postreset_queue: got %0d pending required 0", sb.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] s1;
        test_start("restart2");
        test_last_cycle_hit();
        play_round(8'h04, 8'h04, 7, 1'b0, 1'b0, "late_press");
        play_round(8'h80, 8'h00, 3, 1'b1, 1'b0, "led_drop");
        s1 = m_score;
        test_game_over(s1);
    endtask

    initial begin
        logic [7:0] s0;
        test_reset();
        test_start("start1");
        test_wait_led_ignore();
        play_round(8'h10, 8'h10, 3, 1'b0, 1'b1, "hit");
        play_round(8'h10, 8'h30, 3, 1'b0, 1'b0, "multi_btn");
        test_timeout();
        s0 = m_score;
        test_game_over(s0);
        test_start("restart1");
        test_start_ignored();
        play_round(8'h02, 8'h01, 2, 1'b0, 1'b0, "wrong_btn");
        play_round(8'h02, 8'h02, 1, 1'b0, 1'b1, "hit_fast");
        play_round(8'h03, 8'h01, 2, 1'b0, 1'b1, "hit_subset");
        test_game_over(m_score);
        test_back_to_back();
        test_start("restart3");
        test_reset_mid_round();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/score_calc.md
SCORE_CALC -- requirements
Module: score_calc

Interface
REQ-001 Parameter WINDOW_CYCLES, default 50000000: response window in clk_100mhz cycles after an LED lights (range 2..2^26-1).
REQ-002 Parameter ROUNDS, default 10: rounds per game (range 1..15).
REQ-003 clk_100mhz  in  1  system clock, single clock domain; rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 led_in  in  8  lit-LED vector from the random LED stage (synchronous to clk_100mhz).
REQ-006 btn_in  in  8  player buttons, asynchronous, debounced externally, active-high.
REQ-007 start_in  in  1  game start button, asynchronous, debounced externally, active-high.
REQ-008 clear_out  out  1  one-cycle pulse that clears the random LED stage.
REQ-009 score  out  8  current game score.
REQ-010 rounds  out  4  rounds completed in the current game.
REQ-011 hit_pulse / miss_pulse  out  1 each  one-cycle round-result strobes.
REQ-012 game_over  out  1  high from game completion until the next start.

Function
REQ-013 btn_in and start_in SHALL each pass a 2-flop synchronizer plus a previous-value register; edge = sync & ~prev, giving 3-cycle pin-to-edge latency.
REQ-014 FSM states SHALL be IDLE, WAIT_LED, ARMED, RESOLVE, WAIT_OFF, DONE.
REQ-015 IDLE/DONE: on start edge -> score=0, rounds=0, game_over=0, clear_out=1 for that one cycle, next state WAIT_LED.
REQ-016 WAIT_LED: when led_in != 0 -> ARMED with window counter = 0; button edges in WAIT_LED SHALL be ignored.
REQ-017 ARMED: window counter SHALL increment each cycle; result is decided on the first cycle with any button edge, or on a timeout when the counter equals WINDOW_CYCLES-1.
REQ-018 Hit SHALL be (edges & led_in) != 0 AND (edges & ~led_in) == 0; any other edge pattern, or a timeout, SHALL be a miss.
REQ-019 Simultaneous edge and timeout in the same cycle: the edge SHALL win and be evaluated per REQ-018.
REQ-020 If led_in returns to 0 while ARMED, the round SHALL be scored as a miss.
REQ-021 RESOLVE (exactly one cycle): clear_out=1; hit_pulse or miss_pulse=1; on a hit, score += 1 saturating at 255; rounds += 1.
REQ-022 After RESOLVE -> WAIT_OFF; WAIT_OFF -> (rounds == ROUNDS ? DONE : WAIT_LED) on the first cycle with led_in == 0.
REQ-023 DONE: game_over=1; score and rounds SHALL hold; button edges SHALL be ignored.
REQ-024 start edges outside IDLE/DONE SHALL be ignored.
REQ-025 All outputs SHALL be registered; clear_out, hit_pulse, miss_pulse SHALL never exceed one cycle per event.

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE, score=0, rounds=0, game_over=0, clear_out=0, hit_pulse=0, miss_pulse=0, window counter=0, all synchronizer and previous-value flops = 0.
REQ-027 Reset asserted mid-round SHALL abandon the round with no hit or miss strobe and no score change after release.
REQ-028 A button held through reset release SHALL produce one edge 3 cycles after release, handled per the current state.

Configuration
REQ-029 Macro SCORE_CALC_PENALTY_EN defined: a miss SHALL decrement score by 1, saturating at 0, in RESOLVE.
REQ-030 Macro SCORE_CALC_PENALTY_EN undefined: a miss SHALL leave score unchanged; all other behaviour is identical.

Verification
REQ-031 Hit: start; led_in=8'h10; btn_in[4] pulse -> hit_pulse=1 and clear_out=1 in the same cycle; score=1; rounds=1.
REQ-032 Wrong or multiple buttons: led_in=8'h10; btn_in=8'h30 -> miss_pulse=1; score unchanged (penalty off) or decremented (penalty on, floor 0).
REQ-033 Timeout: WINDOW_CYCLES=8; led_in=8'h01; no press -> miss_pulse on the cycle after 8 cycles in ARMED; edge on the final cycle -> hit.
REQ-034 Game end: ROUNDS=3; three hits -> game_over=1, score=3; further button edges and led_in changes ignored; start -> score=0, rounds=0, clear_out pulse.
REQ-035 Saturation: force 255 hits -> score stays 255; with penalty on, a miss at score=0 stays 0.
REQ-036 Reset: rst_n low during ARMED -> all outputs 0 immediately, IDLE; no strobes after release.
